axi_ad7124_seq: RTL and testbench

// Upstream SPI read sequencer for the AD7124 acquisition path. Holds CS low, waits for DOUT/RDY
// low, issues a data-register read (data+status), then forwards the 4 bytes as an 8-bit stream

---
 rtl/axi_ad7124_seq.sv | 173 +++++++++++++++++
 tb/tb_axi_ad7124_seq.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ad7124_seq.sv
// rtl/axi_ad7124_seq.sv - AD7124 SPI data-register read sequencer with byte stream output
module axi_ad7124_seq #(
    parameter int          CLK_DIV        = 4,
    parameter int          TIMEOUT_CYCLES = 1048576,
    parameter logic [7:0]  CMD_BYTE       = 8'h42
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    output logic       spi_sclk,
    output logic       spi_cs_n,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       trigger,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       busy,
    output logic       err_timeout
);

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_CMD,
        S_READ,
        S_TRIG,
        S_EMIT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              miso_q1;
    logic              miso_s;
    logic [DIV_W-1:0]  div_cnt;
    logic              phase_high;
    logic [4:0]        bit_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [7:0]        cmd_sr;
    logic [31:0]       shift_sr;
    logic [31:0]       hold;
    logic [1:0]        byte_idx;

    logic spi_active;
    logic phase_end;
    logic bit_end;
    logic last_bit;

    assign spi_active = (state == S_CMD) || (state == S_READ);
    assign phase_end  = (div_cnt == DIV_LAST);
    assign bit_end    = spi_active && phase_high && phase_end;
    assign last_bit   = (state == S_CMD) ? (bit_cnt == 5'd7) : (bit_cnt == 5'd31);

    assign busy     = (state != S_IDLE);
    assign spi_cs_n = (state == S_IDLE);
    assign spi_sclk = !spi_active || phase_high;
    assign spi_mosi = (state == S_CMD) ? cmd_sr[7] : 1'b1;
    assign trigger  = (state == S_TRIG) && (shift_sr[3:0] == 4'h0);
    assign m_valid  = (state == S_EMIT);

    // State register; reset aborts any transfer in progress.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and the RDY timeout pulse.
    always_comb begin
        state_next  = state;
        err_timeout = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable) state_next = S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (!enable) begin
                    state_next = S_IDLE;
                end else if (!miso_s) begin
                    state_next = S_CMD;
                end else if (wait_cnt == WAIT_LAST) begin
                    err_timeout = 1'b1;
                    state_next  = S_IDLE;
                end
            end
            S_CMD: begin
                if (bit_end && last_bit) state_next = S_READ;
            end
            S_READ: begin
                if (bit_end && last_bit) state_next = S_TRIG;
            end
            S_TRIG: begin
                state_next = S_EMIT;
            end
            S_EMIT: begin
                if (m_ready && (byte_idx == 2'd3)) begin
                    state_next = enable ? S_WAIT_RDY : S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // MISO synchroniser, SCLK phase/bit counters, shift registers and output byte index.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            miso_q1    <= 1'b1;
            miso_s     <= 1'b1;
            div_cnt    <= '0;
            phase_high <= 1'b0;
            bit_cnt    <= 5'd0;
            wait_cnt   <= '0;
            cmd_sr     <= 8'h00;
            shift_sr   <= 32'h0;
            hold       <= 32'h0;
            byte_idx   <= 2'd0;
        end else begin
            miso_q1 <= spi_miso;
            miso_s  <= miso_q1;

            wait_cnt <= (state == S_WAIT_RDY) ? wait_cnt + WAIT_W'(1) : '0;

            if (state == S_WAIT_RDY) cmd_sr <= CMD_BYTE;

            if (spi_active) begin
                if (phase_end) begin
                    div_cnt    <= '0;
                    phase_high <= !phase_high;
                    if (phase_high) begin
                        bit_cnt <= last_bit ? 5'd0 : bit_cnt + 5'd1;
                        if (state == S_CMD) cmd_sr <= {cmd_sr[6:0], 1'b1};
                        if (state == S_READ) shift_sr <= {shift_sr[30:0], miso_s};
                    end
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end else begin
                div_cnt    <= '0;
                phase_high <= 1'b0;
                bit_cnt    <= 5'd0;
            end

            if (state == S_TRIG) hold <= shift_sr;

            if (state != S_EMIT) begin
                byte_idx <= 2'd0;
            end else if (m_ready) begin
                byte_idx <= byte_idx + 2'd1;
            end
        end
    end

    // Byte selection from the holding register, data bytes first then status.
    always_comb begin
        m_data = 8'h00;
        if (state == S_EMIT) begin
            case (byte_idx)
                2'd0:    m_data = hold[31:24];
                2'd1:    m_data = hold[23:16];
                2'd2:    m_data = hold[15:8];
                default: m_data = hold[7:0];
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ad7124_seq.sv
// tb/tb_axi_ad7124_seq.sv - directed bench for axi_ad7124_seq with a behavioural AD7124 model
module tb_axi_ad7124_seq;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       enable = 1'b0;
    logic       spi_miso = 1'b1;
    logic       m_ready = 1'b1;
    logic       spi_sclk;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       trigger;
    logic       m_valid;
    logic [7:0] m_data;
    logic       busy;
    logic       err_timeout;

    int tests = 0;
    int fails = 0;

    logic [7:0] got[$];
    int trig_cnt = 0;
    int trig_pos = -1;
    int overlap = 0;
    int rises = 0;
    logic [7:0] cmd_seen;

    axi_ad7124_seq #(
        .CLK_DIV(CLK_DIV),
        .TIMEOUT_CYCLES(64),
        .CMD_BYTE(8'h42)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .enable(enable),
        .spi_sclk(spi_sclk),
        .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso),
        .trigger(trigger),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .busy(busy),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Stream and trigger monitor, sampled on the falling clock edge.
    always @(negedge clk) begin
        if (resetn) begin
            if (m_valid && m_ready) got.push_back(m_data);
            if (trigger) begin
                trig_cnt <= trig_cnt + 1;
                trig_pos <= got.size();
            end
            if (trigger && m_valid) overlap <= overlap + 1;
        end
    end

    // ADC model: RDY low, capture command on SCLK rise, drive data on SCLK fall, release DOUT afterwards.
    task automatic adc_convert(input logic [31:0] word, output logic ok);
        int   falls;
        int   cyc;
        logic prev;
        rises    = 0;
        falls    = 0;
        cyc      = 0;
        prev     = spi_sclk;
        cmd_seen = 8'h00;
        spi_miso = 1'b0;
        while (rises < 40 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (!prev && spi_sclk) begin
                rises++;
                if (rises <= 8) cmd_seen = {cmd_seen[6:0], spi_mosi};
            end
            if (prev && !spi_sclk) begin
                falls++;
                if (falls >= 9 && falls <= 40) spi_miso = word[40 - falls];
            end
            prev = spi_sclk;
        end
        ok = (rises == 40);
        repeat (CLK_DIV + 1) @(negedge clk);
        spi_miso = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (spi_sclk !== 1'b1) begin fails++; $display("FAIL reset_sclk got %b want 1", spi_sclk); end
        tests++; if (spi_cs_n !== 1'b1) begin fails++; $display("FAIL reset_cs_n got %b want 1", spi_cs_n); end
        tests++; if (spi_mosi !== 1'b1) begin fails++; $display("FAIL reset_mosi got %b want 1", spi_mosi); end
        tests++; if (trigger !== 1'b0) begin fails++; $display("FAIL reset_trigger got %b want 0", trigger); end
        tests++; if (m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        tests++; if (m_data !== 8'h00) begin fails++; $display("FAIL reset_m_data got %h want 00", m_data); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (err_timeout !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err_timeout); end
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_single();
        int   start;
        int   t0;
        logic ok;
        logic [7:0] exp [4];
        exp = '{8'h12, 8'h34, 8'h56, 8'h00};
        start = got.size();
        t0 = trig_cnt;
        @(posedge clk); #1;
        enable = 1'b1;
        adc_convert(32'h12345600, ok);
        enable = 1'b0;
        repeat (20) @(negedge clk);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL single_sclk_count got %0d want 40", rises); end
        tests++; if (cmd_seen !== 8'h42) begin fails++; $display("FAIL single_mosi_cmd got %h want 42", cmd_seen); end
        tests++; if (trig_cnt - t0 != 1) begin fails++; $display("FAIL single_trigger got %0d want 1", trig_cnt - t0); end
        tests++; if (trig_pos != start) begin fails++; $display("FAIL single_trigger_pos got %0d want %0d", trig_pos, start); end
        tests++; if (got.size() != start + 4) begin fails++; $display("FAIL single_count got %0d want 4", got.size() - start); end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (got.size() <= start + k || got[start + k] !== exp[k]) begin
                fails++;
                $display("FAIL single_byte%0d got %h want %h", k, (got.size() > start + k) ? got[start + k] : 8'hxx, exp[k]);
            end
        end
        tests++; if (overlap != 0) begin fails++; $display("FAIL single_overlap got %0d want 0", overlap); end
        tests++; if (busy !== 1'b0 || spi_cs_n !== 1'b1) begin fails++; $display("FAIL single_idle busy %b cs_n %b want 0 1", busy, spi_cs_n); end
    endtask

    task automatic test_back_to_back();
        int   start;
        int   t0;
        int   bad_ok;
        logic ok;
        logic [31:0] w;
        start = got.size();
        t0 = trig_cnt;
        bad_ok = 0;
        @(posedge clk); #1;
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w = {8'hA0 + 8'(i), 8'hB0 + 8'(i), 8'hC0 + 8'(i), 8'(i)};
            adc_convert(w, ok);
            if (!ok) bad_ok++;
            repeat (10) @(negedge clk);
        end
        enable = 1'b0;
        repeat (20) @(negedge clk);
        tests++; if (bad_ok != 0) begin fails++; $display("FAIL b2b_conversions got %0d incomplete want 0", bad_ok); end
        tests++; if (trig_cnt - t0 != 1) begin fails++; $display("FAIL b2b_trigger_count got %0d want 1", trig_cnt - t0); end
        tests++; if (trig_pos != start) begin fails++; $display("FAIL b2b_trigger_pos got %0d want %0d", trig_pos, start); end
        tests++; if (got.size() != start + 32) begin fails++; $display("FAIL b2b_count got %0d want 32", got.size() - start); end
        for (int i = 0; i < 8; i++) begin
            w = {8'hA0 + 8'(i), 8'hB0 + 8'(i), 8'hC0 + 8'(i), 8'(i)};
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (got.size() <= start + 4 * i + k || got[start + 4 * i + k] !== w[31 - 8 * k -: 8]) begin
                    fails++;
                    $display("FAIL b2b_byte%0d got %h want %h", 4 * i + k,
                             (got.size() > start + 4 * i + k) ? got[start + 4 * i + k] : 8'hxx, w[31 - 8 * k -: 8]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int   start;
        int   t0;
        int   hold_bad;
        int   cyc;
        logic ok;
        logic [7:0] exp [4];
        exp = '{8'h12, 8'h34, 8'h56, 8'h08};
        start = got.size();
        t0 = trig_cnt;
        hold_bad = 0;
        @(posedge clk); #1;
        enable = 1'b1;
        fork
            adc_convert(32'h12345608, ok);
            begin
                cyc = 0;
                do begin
                    @(posedge clk); #1;
                    cyc++;
                end while (!(m_valid && got.size() == start + 1) && cyc < 2000);
                m_ready = 1'b0;
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    if (m_valid !== 1'b1 || m_data !== 8'h34) hold_bad++;
                end
                @(posedge clk); #1;
                m_ready = 1'b1;
            end
        join
        enable = 1'b0;
        repeat (20) @(negedge clk);
        tests++; if (cyc >= 2000) begin fails++; $display("FAIL bp_second_byte got timeout want byte 34 presented"); end
        tests++; if (hold_bad != 0) begin fails++; $display("FAIL bp_hold got %0d bad cycles want 0", hold_bad); end
        tests++; if (trig_cnt - t0 != 0) begin fails++; $display("FAIL bp_no_trigger got %0d want 0", trig_cnt - t0); end
        tests++; if (got.size() != start + 4) begin fails++; $display("FAIL bp_count got %0d want 4", got.size() - start); end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (got.size() <= start + k || got[start + k] !== exp[k]) begin
                fails++;
                $display("FAIL bp_byte%0d got %h want %h", k, (got.size() > start + k) ? got[start + k] : 8'hxx, exp[k]);
            end
        end
    endtask

    task automatic test_timeout();
        int n;
        int cyc;
        int found;
        enable = 1'b0;
        spi_miso = 1'b1;
        cyc = 0;
        while (busy && cyc < 200) begin @(negedge clk); cyc++; end
        repeat (3) @(posedge clk);
        #1;
        enable = 1'b1;
        n = 0;
        found = 0;
        for (int c = 0; c < 300 && found == 0; c++) begin
            @(negedge clk);
            if (!spi_cs_n) n++;
            if (err_timeout) found = 1;
        end
        tests++; if (found != 1 || n != 64) begin fails++; $display("FAIL timeout_cycle got %0d (seen %0d) want 64", n, found); end
        @(negedge clk);
        tests++; if (spi_cs_n !== 1'b1 || err_timeout !== 1'b0) begin fails++; $display("FAIL timeout_release cs_n %b err %b want 1 0", spi_cs_n, err_timeout); end
        @(negedge clk);
        tests++; if (spi_cs_n !== 1'b0) begin fails++; $display("FAIL timeout_reassert got %b want 0", spi_cs_n); end
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_reset_mid_read();
        int   falls;
        int   cyc;
        int   start;
        int   t0;
        logic prev;
        logic ok;
        logic [7:0] exp [4];
        exp = '{8'h0A, 8'h0B, 8'h0C, 8'h00};
        @(posedge clk); #1;
        enable = 1'b1;
        spi_miso = 1'b0;
        falls = 0;
        cyc = 0;
        prev = spi_sclk;
        while (falls < 26 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (prev && !spi_sclk) falls++;
            prev = spi_sclk;
        end
        tests++; if (falls != 26) begin fails++; $display("FAIL rst_reach_bit17 got %0d falls want 26", falls); end
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tests++; if (spi_cs_n !== 1'b1 || spi_sclk !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_abort cs_n %b sclk %b m_valid %b busy %b want 1 1 0 0", spi_cs_n, spi_sclk, m_valid, busy);
        end
        spi_miso = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (2) @(posedge clk);
        start = got.size();
        t0 = trig_cnt;
        adc_convert(32'h0A0B0C00, ok);
        enable = 1'b0;
        repeat (20) @(negedge clk);
        tests++; if (ok !== 1'b1 || cmd_seen !== 8'h42) begin fails++; $display("FAIL rst_clean_cmd got %h want 42", cmd_seen); end
        tests++; if (trig_cnt - t0 != 1) begin fails++; $display("FAIL rst_clean_trigger got %0d want 1", trig_cnt - t0); end
        tests++; if (got.size() != start + 4) begin fails++; $display("FAIL rst_clean_count got %0d want 4", got.size() - start); end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (got.size() <= start + k || got[start + k] !== exp[k]) begin
                fails++;
                $display("FAIL rst_clean_byte%0d got %h want %h", k, (got.size() > start + k) ? got[start + k] : 8'hxx, exp[k]);
            end
        end
    endtask

    task automatic test_disable_in_read();
        int   start;
        int   t0;
        int   cyc;
        int   woke;
        logic ok;
        logic [7:0] exp [4];
        exp = '{8'hFE, 8'hDC, 8'hBA, 8'h70};
        start = got.size();
        t0 = trig_cnt;
        rises = 0;
        @(posedge clk); #1;
        enable = 1'b1;
        fork
            adc_convert(32'hFEDCBA70, ok);
            begin
                cyc = 0;
                while (rises < 12 && cyc < 2000) begin @(negedge clk); cyc++; end
                @(posedge clk); #1;
                enable = 1'b0;
            end
        join
        cyc = 0;
        while (busy && cyc < 200) begin @(negedge clk); cyc++; end
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL dis_conversion got %0d rises want 40", rises); end
        tests++; if (got.size() != start + 4) begin fails++; $display("FAIL dis_count got %0d want 4", got.size() - start); end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (got.size() <= start + k || got[start + k] !== exp[k]) begin
                fails++;
                $display("FAIL dis_byte%0d got %h want %h", k, (got.size() > start + k) ? got[start + k] : 8'hxx, exp[k]);
            end
        end
        tests++; if (trig_cnt - t0 != 1) begin fails++; $display("FAIL dis_trigger got %0d want 1", trig_cnt - t0); end
        woke = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy !== 1'b0 || spi_cs_n !== 1'b1) woke++;
        end
        tests++; if (woke != 0) begin fails++; $display("FAIL dis_idle got %0d busy cycles want 0", woke); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_timeout();
        test_reset_mid_read();
        test_disable_in_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
